// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: queued prediction entry and FSM state.
package bru_pkg;

  localparam int unsigned BRU_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [BRU_ADDR_WIDTH-1:0] pc;
    logic                      taken;
    logic [BRU_ADDR_WIDTH-1:0] trgt;
  } pred_entry_t;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Synchronous FIFO of in-flight predictions; pointers carry an extra MSB so
// full and empty are told apart without a separate counter. Clear dominates push/pop.
module pred_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t din,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_r;
  logic [PW:0]  rd_ptr_r;
  pred_entry_t  mem_r [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                     (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign head      = mem_r[rd_ptr_r[PW-1:0]];
  assign do_push_s = push && !full && !clear;
  assign do_pop_s  = pop && !empty && !clear;

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[PW-1:0]] <= din;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued fetch predictions against in-order EX resolutions, issues
// redirect/flush and predictor/BTB updates. Optional counters: BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = BRU_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid_i,
  input  logic [ADDR_WIDTH-1:0] pred_pc_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_trgt_i,
  output logic                  pred_ready_o,
  input  logic                  res_valid_i,
  input  logic [ADDR_WIDTH-1:0] res_pc_i,
  input  logic                  res_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_trgt_i,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  upd_pred_en_o,
  output logic                  upd_btb_en_o,
  output logic [ADDR_WIDTH-1:0] upd_pc_o,
  output logic                  upd_taken_o,
  output logic [ADDR_WIDTH-1:0] upd_trgt_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           stat_br_cnt_o,
  output logic [31:0]           stat_mispred_cnt_o
`endif
);

  bru_state_e  state_r;
  bru_state_e  next_state_s;
  pred_entry_t din_s;
  pred_entry_t head_s;
  logic        full_s;
  logic        empty_s;
  logic        in_normal_s;
  logic        push_s;
  logic        res_fire_s;
  logic        match_s;
  logic        mispred_s;
  logic        pop_s;
  logic [ADDR_WIDTH-1:0] next_pc_s;

  assign in_normal_s  = (state_r == NORMAL);
  assign pred_ready_o = !full_s;
  assign push_s       = pred_valid_i && !full_s && in_normal_s;
  assign res_fire_s   = res_valid_i && in_normal_s;
  assign pop_s        = res_fire_s && match_s;
  assign din_s        = '{pc: pred_pc_i, taken: pred_taken_i, trgt: pred_trgt_i};
  assign next_pc_s    = res_taken_i ? res_trgt_i : (res_pc_i + ADDR_WIDTH'(INSTR_BYTES));

  pred_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .clear (mispred_s),
    .din   (din_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Head match and mispredict detection; an unmatched branch was implicitly predicted not-taken.
  always_comb begin
    match_s   = 1'b0;
    mispred_s = 1'b0;
    if (res_fire_s) begin
      match_s = !empty_s && (head_s.pc == res_pc_i);
      if (match_s) begin
        mispred_s = (head_s.taken != res_taken_i) ||
                    (res_taken_i && (head_s.trgt != res_trgt_i));
      end else begin
        mispred_s = res_taken_i;
      end
    end else begin
      match_s   = 1'b0;
      mispred_s = 1'b0;
    end
  end

  // FSM next state: a mispredict spends exactly one cycle in FLUSH.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      NORMAL:  next_state_s = mispred_s ? FLUSH : NORMAL;
      FLUSH:   next_state_s = NORMAL;
      default: next_state_s = NORMAL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= NORMAL;
    else      state_r <= next_state_s;
  end

  // Registered redirect and update outputs; enables pulse, buses hold the last resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      upd_pred_en_o <= 1'b0;
      upd_btb_en_o  <= 1'b0;
      upd_pc_o      <= '0;
      upd_taken_o   <= 1'b0;
      upd_trgt_o    <= '0;
    end else begin
      redirect_o    <= mispred_s;
      upd_pred_en_o <= res_fire_s;
      upd_btb_en_o  <= res_fire_s && res_taken_i;
      if (res_fire_s) begin
        redirect_pc_o <= next_pc_s;
        upd_pc_o      <= res_pc_i;
        upd_taken_o   <= res_taken_i;
        upd_trgt_o    <= res_trgt_i;
      end
    end
  end

`ifdef BRU_STATS_EN
  // Saturating resolution and mispredict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_cnt_o      <= 32'd0;
      stat_mispred_cnt_o <= 32'd0;
    end else begin
      if (res_fire_s && (stat_br_cnt_o != 32'hFFFF_FFFF))
        stat_br_cnt_o <= stat_br_cnt_o + 32'd1;
      if (mispred_s && (stat_mispred_cnt_o != 32'hFFFF_FFFF))
        stat_mispred_cnt_o <= stat_mispred_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default build; BRU_STATS_EN optional).
module tb_branch_resolve_unit;
  import bru_pkg::*;

  logic        clk;
  logic        rst;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_trgt_i;
  logic        pred_ready_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_trgt_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        upd_pred_en_o;
  logic        upd_btb_en_o;
  logic [31:0] upd_pc_o;
  logic        upd_taken_o;
  logic [31:0] upd_trgt_o;
`ifdef BRU_STATS_EN
  logic [31:0] stat_br_cnt_o;
  logic [31:0] stat_mispred_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid_i  (pred_valid_i),
    .pred_pc_i     (pred_pc_i),
    .pred_taken_i  (pred_taken_i),
    .pred_trgt_i   (pred_trgt_i),
    .pred_ready_o  (pred_ready_o),
    .res_valid_i   (res_valid_i),
    .res_pc_i      (res_pc_i),
    .res_taken_i   (res_taken_i),
    .res_trgt_i    (res_trgt_i),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .upd_pred_en_o (upd_pred_en_o),
    .upd_btb_en_o  (upd_btb_en_o),
    .upd_pc_o      (upd_pc_o),
    .upd_taken_o   (upd_taken_o),
    .upd_trgt_o    (upd_trgt_o)
`ifdef BRU_STATS_EN
    ,
    .stat_br_cnt_o      (stat_br_cnt_o),
    .stat_mispred_cnt_o (stat_mispred_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid_i = 1'b1;
    pred_pc_i    = pc;
    pred_taken_i = tk;
    pred_trgt_i  = tg;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    res_valid_i = 1'b1;
    res_pc_i    = pc;
    res_taken_i = tk;
    res_trgt_i  = tg;
  endtask

  initial begin
    rst = 1'b0;
    pred_valid_i = 1'b0; pred_pc_i = 32'h0; pred_taken_i = 1'b0; pred_trgt_i = 32'h0;
    res_valid_i  = 1'b0; res_pc_i  = 32'h0; res_taken_i  = 1'b0; res_trgt_i  = 32'h0;

    // Reset state
    #3;
    check_val("rst_ready",    pred_ready_o,  1'b1);
    check_val("rst_redirect", redirect_o,    1'b0);
    check_val("rst_rpc",      redirect_pc_o, 32'h0);
    check_val("rst_upd_en",   upd_pred_en_o, 1'b0);
    check_val("rst_btb_en",   upd_btb_en_o,  1'b0);
    check_val("rst_upd_pc",   upd_pc_o,      32'h0);
    #7 rst = 1'b1;
    tick();

    // Correct taken prediction
    set_push(32'h100, 1'b1, 32'h200); tick();
    set_res(32'h100, 1'b1, 32'h200);  tick();
    check_val("a_upd_en",   upd_pred_en_o, 1'b1);
    check_val("a_btb_en",   upd_btb_en_o,  1'b1);
    check_val("a_redirect", redirect_o,    1'b0);
    check_val("a_upd_pc",   upd_pc_o,      32'h100);
    check_val("a_upd_tk",   upd_taken_o,   1'b1);
    check_val("a_upd_tg",   upd_trgt_o,    32'h200);
    tick();
    check_val("a_pulse_upd", upd_pred_en_o, 1'b0);
    check_val("a_pulse_btb", upd_btb_en_o,  1'b0);
    // FIFO must now be empty: same taken branch misses and redirects
    set_res(32'h100, 1'b1, 32'h200); tick();
    check_val("a_empty_redir", redirect_o,    1'b1);
    check_val("a_empty_rpc",   redirect_pc_o, 32'h200);
    tick();
    check_val("a_redir_pulse", redirect_o, 1'b0);

    // Direction mispredict, flush drops younger entry and wrong-path traffic
    set_push(32'h100, 1'b1, 32'h200); tick();
    set_push(32'h180, 1'b1, 32'h1C0); tick();
    set_res(32'h100, 1'b0, 32'h0);    tick();
    check_val("b_redirect", redirect_o,    1'b1);
    check_val("b_rpc",      redirect_pc_o, 32'h104);
    check_val("b_btb_en",   upd_btb_en_o,  1'b0);
    set_push(32'h300, 1'b1, 32'h380);
    set_res(32'h300, 1'b1, 32'h380);  tick();
    check_val("b_flush_redir", redirect_o,    1'b0);
    check_val("b_flush_upd",   upd_pred_en_o, 1'b0);
    set_res(32'h180, 1'b0, 32'h0);    tick();
    check_val("b_cleared_180", redirect_o, 1'b0);
    set_res(32'h300, 1'b0, 32'h0);    tick();
    check_val("b_dropped_300", redirect_o, 1'b0);
    check_val("b_upd_en",      upd_pred_en_o, 1'b1);

    // BTB miss handling
    set_res(32'h400, 1'b1, 32'h480); tick();
    check_val("c_redirect", redirect_o,    1'b1);
    check_val("c_rpc",      redirect_pc_o, 32'h480);
    check_val("c_btb_en",   upd_btb_en_o,  1'b1);
    tick();
    set_res(32'h500, 1'b0, 32'h0);   tick();
    check_val("c_nt_redirect", redirect_o,    1'b0);
    check_val("c_nt_btb_en",   upd_btb_en_o,  1'b0);
    check_val("c_nt_upd_en",   upd_pred_en_o, 1'b1);
    check_val("c_nt_rpc",      redirect_pc_o, 32'h504);

    // Full FIFO, dropped pushes, no ready bypass
    for (int k = 0; k < 4; k++) begin
      check_val("d_ready_fill", pred_ready_o, 1'b1);
      set_push(32'h1000 + 32'(k * 4), 1'b1, 32'h3000 + 32'(k * 4)); tick();
    end
    check_val("d_full", pred_ready_o, 1'b0);
    set_push(32'h1010, 1'b1, 32'h3010); tick();
    check_val("d_full_still", pred_ready_o, 1'b0);
    set_res(32'h1000, 1'b1, 32'h3000);
    set_push(32'h1014, 1'b1, 32'h3014); tick();
    check_val("d_pop_redir", redirect_o,   1'b0);
    check_val("d_ready_back", pred_ready_o, 1'b1);
    for (int k = 1; k < 4; k++) begin
      set_res(32'h1000 + 32'(k * 4), 1'b1, 32'h3000 + 32'(k * 4)); tick();
      check_val("d_drain_order", redirect_o, 1'b0);
    end
    set_res(32'h1014, 1'b1, 32'h3014); tick();
    check_val("d_push_dropped", redirect_o, 1'b1);
    tick();

    // Pointer wrap over several fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        set_push(32'h2000 + 32'(r * 64 + i * 4), 1'b1, 32'h2100 + 32'(r * 64 + i * 4)); tick();
      end
      for (int i = 0; i < 3; i++) begin
        set_res(32'h2000 + 32'(r * 64 + i * 4), 1'b1, 32'h2100 + 32'(r * 64 + i * 4)); tick();
        check_val("w_redirect", redirect_o, 1'b0);
        check_val("w_upd_pc",   upd_pc_o,   32'h2000 + 32'(r * 64 + i * 4));
      end
    end

    // Target mismatch and PC wrap
    set_push(32'h10, 1'b1, 32'h40); tick();
    set_res(32'h10, 1'b1, 32'h80);  tick();
    check_val("e_tgt_redir", redirect_o,    1'b1);
    check_val("e_tgt_rpc",   redirect_pc_o, 32'h80);
    tick();
    set_push(32'hFFFF_FFFC, 1'b1, 32'h1234); tick();
    set_res(32'hFFFF_FFFC, 1'b0, 32'h0);     tick();
    check_val("e_wrap_redir", redirect_o,    1'b1);
    check_val("e_wrap_rpc",   redirect_pc_o, 32'h0);
    tick();

    // Asynchronous reset during FLUSH
    set_push(32'h100, 1'b1, 32'h200); tick();
    set_res(32'h100, 1'b0, 32'h0);    tick();
    check_val("f_redirect", redirect_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_val("f_rst_redir",  redirect_o,    1'b0);
    check_val("f_rst_rpc",    redirect_pc_o, 32'h0);
    check_val("f_rst_upd_en", upd_pred_en_o, 1'b0);
    check_val("f_rst_upd_pc", upd_pc_o,      32'h0);
    check_val("f_rst_ready",  pred_ready_o,  1'b1);
`ifdef BRU_STATS_EN
    check_val("f_stat_br",  stat_br_cnt_o,      32'h0);
    check_val("f_stat_mis", stat_mispred_cnt_o, 32'h0);
`endif
    #1 rst = 1'b1;
    tick();
    check_val("f_no_redir", redirect_o, 1'b0);
    set_push(32'h700, 1'b1, 32'h740); tick();
    set_res(32'h700, 1'b1, 32'h740);  tick();
    check_val("f_normal_redir", redirect_o,    1'b0);
    check_val("f_normal_upd",   upd_pred_en_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart to the fetch-side branch predictor/BTB.
- Queues each prediction fetch makes and compares it against the in-order branch resolution from EX.
- On a mispredict, issues the redirect/flush.
- Produces the update writes consumed by the predictor (brnch_taken_i/write_en_i) and the BTB (addr_i/data_i/write_en_i).

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- FIFO_DEPTH, 4, in-flight prediction entries; power of two, ≥2.
- INSTR_BYTES, 4, fall-through increment (PC + INSTR_BYTES).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- pred_valid_i  in  1  fetch pushes a prediction (BTB hit).
- pred_pc_i  in  ADDR_WIDTH  PC of predicted instruction.
- pred_taken_i  in  1  predicted direction.
- pred_trgt_i  in  ADDR_WIDTH  predicted target.
- pred_ready_o  out  1  FIFO not full.
- res_valid_i  in  1  EX resolved a branch this cycle (program order).
- res_pc_i  in  ADDR_WIDTH  PC of resolved branch.
- res_taken_i  in  1  actual direction.
- res_trgt_i  in  ADDR_WIDTH  actual target.
- redirect_o  out  1  one-cycle mispredict pulse; also flush to fetch/decode.
- redirect_pc_o  out  ADDR_WIDTH  correct next PC.
- upd_pred_en_o  out  1  predictor write enable.
- upd_btb_en_o  out  1  BTB write enable.
- upd_pc_o  out  ADDR_WIDTH  update address.
- upd_taken_o  out  1  actual direction, to predictor.
- upd_trgt_o  out  ADDR_WIDTH  target data, to BTB.

Behaviour:
- Reset (rst=0, async): FIFO empty, state NORMAL, pred_ready_o=1. All other outputs 0, including redirect_pc_o and upd_* buses.
- Push: accepted when pred_valid_i && pred_ready_o && state==NORMAL. pred_ready_o=!full, combinational from count. Push with ready low is dropped.
- Resolution (state NORMAL, res_valid_i=1): match = !empty && head.pc==res_pc_i.
  - match: pop head. mispredict = (head.taken != res_taken_i) || (res_taken_i && head.trgt != res_trgt_i).
  - no match: BTB miss, implicit predict not-taken. No pop. mispredict = res_taken_i.
- Simultaneous push and pop when full: pop frees a slot next cycle only. Ready is not bypassed.
- Outputs registered; one-cycle latency after res_valid_i:
  - upd_pred_en_o=1, upd_btb_en_o=res_taken_i.
  - upd_pc_o/upd_taken_o/upd_trgt_o = resolution values.
  - redirect_o=mispredict.
  - redirect_pc_o = res_taken_i ? res_trgt_i : res_pc_i+INSTR_BYTES, modulo 2^ADDR_WIDTH (wraps).
- FSM:
  - NORMAL→FLUSH on mispredict. On that edge, FIFO cleared, which drops any same-cycle push.
  - FLUSH lasts exactly one cycle, coinciding with redirect_o=1. In FLUSH, pushes and resolutions are ignored (wrong path); FLUSH→NORMAL.
- Back-to-back resolutions accepted every NORMAL cycle. upd_*_en_o and redirect_o are strictly single-cycle pulses unless re-triggered.
- Async reset mid-FLUSH: returns to NORMAL, empty; no redirect emitted afterwards.

Optional Feature:
- BRU_STATS_EN defined:
  - Adds stat_br_cnt_o[31:0], counting resolved branches in NORMAL.
  - Adds stat_mispred_cnt_o[31:0], counting mispredicts.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package bru_pkg: typedef pred_entry_t {pc, taken, trgt} parameterised by ADDR_WIDTH via package localparam; enum bru_state_e {NORMAL, FLUSH}.
- One sub-module: pred_fifo (sync FIFO: push/pop/clear, full/empty, head output, wrap-around pointers with extra MSB).

Test Plan:
- Push {pc=0x100, taken=1, trgt=0x200}; resolve pc=0x100 taken=1 trgt=0x200 → next cycle upd_pred_en_o=1, upd_btb_en_o=1, redirect_o=0, FIFO empty.
- Push {0x100,1,0x200}; resolve 0x100 taken=0 → redirect_o=1, redirect_pc_o=0x104. One FLUSH cycle ignores a concurrent push of 0x300 and a resolve; FIFO empty after.
- Empty FIFO; resolve pc=0x400 taken=1 trgt=0x480 → redirect_o=1, redirect_pc_o=0x480, upd_btb_en_o=1. Resolve 0x500 taken=0 → no redirect, upd_btb_en_o=0.
- Push 4 entries → pred_ready_o=0; 5th push dropped. Pop one with simultaneous push → push dropped, ready=1 next cycle. Wrap pointers over 3 fill/drain cycles with in-order head PCs.
- Target mismatch: pred {0x10,1,0x40}, resolve 0x10 taken=1 trgt=0x80 → redirect_pc_o=0x80. Resolve pc=0xFFFFFFFC not-taken with a taken prediction → redirect_pc_o=0x00000000.
- Assert rst=0 asynchronously during FLUSH → all outputs 0 immediately; after release pred_ready_o=1, state NORMAL. With BRU_STATS_EN, counters read 0.
